alus_serial: RTL and testbench

Bit-serial shift/rotate engine for the Gumnut datapath: it accepts an 8-bit operand, a 3-bit count and a 2-bit operation over a valid/ready request channel. It performs one single-bit shift or rotate per clock, then returns the 8-bit result and carry-out over a valid/ready response channel. Its results are bit-exact with the single-cycle shift unit, with the same `s` encoding and the same carry rules. It is used where area matters more than latency, and as a cross-check engine in shift-unit verification.

---
 rtl/alus_serial.sv | 106 ++++++++++
 tb/tb_alus_serial.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alus_serial.sv
// Bit-serial shift/rotate engine: one single-bit shift or rotate per clock,
// bit-exact with the single-cycle shift unit, behind valid/ready handshakes.
module alus_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [2:0] cnt,
    input  logic [1:0] s,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       co,
    output logic       busy
);
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] r_q, r_nxt;
    logic              c_q, c_nxt;
    logic [CNT_W-1:0]  k_q, k_nxt;
    logic [1:0]        op_q, op_nxt;

    // One single-bit step; returns {carry, value}. Rotates leave the carry alone.
    function automatic logic [DATA_W:0] step(input logic [1:0] op,
                                             input logic [DATA_W-1:0] r,
                                             input logic c);
        case (op)
            OP_SHL:  step = {r[DATA_W-1], r[DATA_W-2:0], 1'b0};
            OP_SHR:  step = {r[0], 1'b0, r[DATA_W-1:1]};
            OP_ROL:  step = {c, r[DATA_W-2:0], r[DATA_W-1]};
            default: step = {c, r[0], r[DATA_W-1:1]};
        endcase
    endfunction

    // Rotate carry is the bit that wrapped last, which is where it now sits in R.
    function automatic logic carry_out(input logic [1:0] op,
                                       input logic [DATA_W-1:0] r,
                                       input logic c);
        case (op)
            OP_ROL:  carry_out = r[0];
            OP_ROR:  carry_out = r[DATA_W-1];
            default: carry_out = c;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        r_nxt     = r_q;
        c_nxt     = c_q;
        k_nxt     = k_q;
        op_nxt    = op_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    r_nxt     = a;
                    k_nxt     = cnt;
                    op_nxt    = s;
                    c_nxt     = 1'b0;
                    state_nxt = (cnt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                {c_nxt, r_nxt} = step(op_q, r_q, c_q);
                k_nxt          = k_q - 3'd1;
                if (k_q == 3'd1) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r_q   <= '0;
            c_q   <= 1'b0;
            k_q   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            r_q   <= r_nxt;
            c_q   <= c_nxt;
            k_q   <= k_nxt;
            op_q  <= op_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = r_q;
    assign co        = carry_out(op_q, r_q, c_q);

endmodule

// File: tb/tb_alus_serial.sv
// Directed and exhaustive checks of the bit-serial shift/rotate engine.
module tb_alus_serial;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [2:0] cnt = '0;
    logic [1:0] s = '0;
    logic       in_ready, out_valid, co, busy;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;
    int sent = 0;
    int resp = 0;
    logic ov_q = 1'b0;

    alus_serial dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .cnt(cnt), .s(s), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .co(co), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count emitted responses as rising edges of out_valid.
    always @(negedge clk) begin
        if (out_valid && !ov_q) resp++;
        ov_q <= out_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference semantics: returns {co, result}.
    function automatic logic [8:0] model(input logic [1:0] op, input logic [7:0] av,
                                         input logic [2:0] n);
        logic [8:0]  t;
        logic [15:0] d;
        logic [7:0]  rr;
        case (op)
            2'b00: begin t = {1'b0, av} << n; model = t; end
            2'b01: begin t = {av, 1'b0} >> n; model = {t[0], t[8:1]}; end
            2'b10: begin d = {av, av} << n; rr = d[15:8]; model = {rr[0], rr}; end
            default: begin d = {av, av} >> n; rr = d[7:0]; model = {rr[7], rr}; end
        endcase
    endfunction

    // One full transaction starting at a negedge in IDLE; ends at the negedge after the handshake.
    task automatic txn(input logic [1:0] op, input logic [7:0] av, input logic [2:0] n,
                       input int hold, input logic [7:0] exp_r, input logic exp_c);
        int lat;
        int bcnt;
        logic [7:0] r0;
        logic c0;
        s = op; a = av; cnt = n; in_valid = 1'b1; out_ready = (hold == 0);
        chk("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; a = ~av; cnt = ~n; s = ~op;
        sent++;
        lat = 1; bcnt = 0;
        while (!out_valid && lat <= 9) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, n + 1);
        chk("run_busy_cycles", bcnt, n);
        chk("out_valid", out_valid, 1);
        chk("busy_done", busy, 1);
        r0 = result; c0 = co;
        for (int i = 0; i < hold; i++) begin
            chk("in_ready_done", in_ready, 0);
            @(negedge clk);
            chk("hold_result", result, r0);
            chk("hold_co", co, c0);
        end
        out_ready = 1'b1;
        chk("result", result, exp_r);
        chk("co", co, exp_c);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        int lat;
        int resp0;
        logic [8:0] e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 8'h00);
        chk("rst_co", co, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        txn(2'b00, 8'h96, 3'd3, 0, 8'hB0, 1'b0);
        txn(2'b01, 8'h96, 3'd2, 0, 8'h25, 1'b1);
        txn(2'b00, 8'hFF, 3'd0, 0, 8'hFF, 1'b0);
        txn(2'b10, 8'h81, 3'd1, 0, 8'h03, 1'b1);
        txn(2'b11, 8'h81, 3'd4, 2, 8'h18, 1'b0);
        txn(2'b11, 8'h80, 3'd0, 0, 8'h80, 1'b1);
        txn(2'b01, 8'h96, 3'd0, 1, 8'h96, 1'b0);
        txn(2'b10, 8'h80, 3'd0, 0, 8'h80, 1'b0);

        // Backpressure with in_valid held high and a toggled
        s = 2'b10; a = 8'h5A; cnt = 3'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        sent++;
        s = 2'b00; cnt = 3'd1;
        lat = 1;
        while (!out_valid && lat <= 9) begin
            chk("bp_in_ready_run", in_ready, 0);
            a = ~a;
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 8'h2D);
            chk("bp_co", co, 1);
            chk("bp_in_ready", in_ready, 0);
            a = a ^ 8'h3C;
            @(negedge clk);
        end
        chk("bp_result_last", result, 8'h2D);
        a = 8'h0F; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_after_in_ready", in_ready, 1);
        chk("bp_after_busy", busy, 0);
        chk("bp_after_out_valid", out_valid, 0);
        @(negedge clk);
        sent++;
        in_valid = 1'b0;
        chk("bp_second_accepted", busy, 1);
        @(negedge clk);
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_result", result, 8'h1E);
        chk("bp_second_co", co, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the 3rd RUN cycle
        resp0 = resp;
        s = 2'b00; a = 8'h01; cnt = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 8'h00);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("abort_no_response", resp, resp0);
        txn(2'b01, 8'h80, 3'd7, 0, 8'h01, 1'b0);

        // Exhaustive sweep with random gaps and backpressure
        for (int op = 0; op < 4; op++) begin
            for (int n = 0; n < 8; n++) begin
                for (int av = 0; av < 256; av++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    e = model(op[1:0], av[7:0], n[2:0]);
                    txn(op[1:0], av[7:0], n[2:0], ($urandom_range(0, 3) == 0) ? 1 : 0,
                        e[7:0], e[8]);
                end
            end
        end
        @(negedge clk);
        chk("response_count", resp, sent);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
